// File: rtl/udp_tx_arbiter_pkg.sv
// Shared types and constants for the two-channel UDP transmit arbiter.
// Imported by the arbiter top level.
package udp_tx_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    HDR     = 2'd1,
    PAYLOAD = 2'd2
  } state_t;

  localparam int NUM_CH        = 2;
  localparam int PKT_WORDS_DEF = 1024;
  localparam int UDP_HDR_LEN   = 8;
  localparam int WORD_BYTES    = 8;

endpackage

// File: rtl/udp_rr_select2.sv
// Combinational two-way round-robin pick: the channel that did not win last
// time is preferred when both are eligible.
module udp_rr_select2 (
  input  logic [1:0] elig,
  input  logic       last_sel,
  output logic       grant,
  output logic       any_eligible
);

  always_comb begin
    grant = 1'b0;
    case (elig)
      2'b01:   grant = 1'b0;
      2'b10:   grant = 1'b1;
      2'b11:   grant = ~last_sel;
      default: grant = 1'b0;
    endcase
  end

  assign any_eligible = |elig;

endmodule

// File: rtl/udp_tx_arbiter.sv
// Drains fixed-size datagrams from two FWFT FIFOs into a UDP header/payload
// stream, alternating between channels when both have a full datagram queued.
module udp_tx_arbiter
  import udp_tx_arbiter_pkg::*;
#(
  parameter int          PKT_WORDS = PKT_WORDS_DEF,
  parameter logic [15:0] PORT0     = 16'd1234,
  parameter logic [15:0] PORT1     = 16'd1235
) (
  input  logic        xgmii_clk,
  input  logic        xgmii_rst,
  input  logic        enable,
  input  logic [31:0] peer_ip,
  input  logic        peer_valid,
  input  logic [12:0] ch0_count,
  input  logic [63:0] ch0_tdata,
  output logic        ch0_rden,
  input  logic [12:0] ch1_count,
  input  logic [63:0] ch1_tdata,
  output logic        ch1_rden,
  output logic        m_udp_hdr_valid,
  input  logic        m_udp_hdr_ready,
  output logic [31:0] m_udp_dest_ip,
  output logic [15:0] m_udp_port,
  output logic [15:0] m_udp_length,
  output logic [63:0] m_udp_payload_axis_tdata,
  output logic        m_udp_payload_axis_tvalid,
  input  logic        m_udp_payload_axis_tready,
  output logic        m_udp_payload_axis_tlast,
  output logic        busy,
  output logic [31:0] pkt_cnt0,
  output logic [31:0] pkt_cnt1
);

  localparam int              CW       = (PKT_WORDS > 1) ? $clog2(PKT_WORDS) : 1;
  localparam logic [CW-1:0]   LAST_IDX = CW'(PKT_WORDS - 1);
  localparam logic [13:0]     ELIG_TH  = 14'(PKT_WORDS);

  state_t                       state, state_nxt;
  logic                         sel, last_sel;
  logic                         grant, any_elig;
  logic                         start, hdr_hs, pay_hs, last_hs;
  logic [CW-1:0]                word_cnt;
  logic [NUM_CH-1:0]            elig;
  logic [NUM_CH-1:0]            rden;
  logic [NUM_CH-1:0][12:0]      ch_count;
  logic [NUM_CH-1:0][63:0]      ch_tdata;
  logic [NUM_CH-1:0][31:0]      pkt_cnt;

  assign ch_count = {ch1_count, ch0_count};
  assign ch_tdata = {ch1_tdata, ch0_tdata};

  // Eligibility only matters in IDLE; the FSM ignores it everywhere else.
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    assign elig[i] = {1'b0, ch_count[i]} >= ELIG_TH;
    assign rden[i] = pay_hs & (sel == 1'(i));
  end

  udp_rr_select2 u_rr (
    .elig         (elig),
    .last_sel     (last_sel),
    .grant        (grant),
    .any_eligible (any_elig)
  );

  assign start   = (state == IDLE) & enable & peer_valid & any_elig;
  assign hdr_hs  = m_udp_hdr_valid & m_udp_hdr_ready;
  assign pay_hs  = m_udp_payload_axis_tvalid & m_udp_payload_axis_tready;
  assign last_hs = pay_hs & m_udp_payload_axis_tlast;

  assign m_udp_hdr_valid           = (state == HDR);
  assign m_udp_payload_axis_tvalid = (state == PAYLOAD);
  assign m_udp_payload_axis_tlast  = m_udp_payload_axis_tvalid & (word_cnt == LAST_IDX);
  assign m_udp_payload_axis_tdata  = m_udp_payload_axis_tvalid ? ch_tdata[sel] : '0;
  assign m_udp_port                = sel ? PORT1 : PORT0;
  assign m_udp_length              = 16'(PKT_WORDS * WORD_BYTES + UDP_HDR_LEN);
  assign busy                      = (state != IDLE);
  assign ch0_rden                  = rden[0];
  assign ch1_rden                  = rden[1];
  assign pkt_cnt0                  = pkt_cnt[0];
  assign pkt_cnt1                  = pkt_cnt[1];

  always_ff @(posedge xgmii_clk) begin
    if (xgmii_rst) state <= IDLE;
    else           state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start)   state_nxt = HDR;
      HDR:     if (hdr_hs)  state_nxt = PAYLOAD;
      PAYLOAD: if (last_hs) state_nxt = IDLE;
      default:              state_nxt = IDLE;
    endcase
  end

  // last_sel resets to 1 so channel 0 takes the first tie.
  always_ff @(posedge xgmii_clk) begin
    if (xgmii_rst) begin
      sel           <= 1'b0;
      last_sel      <= 1'b1;
      word_cnt      <= '0;
      m_udp_dest_ip <= '0;
      pkt_cnt       <= '0;
    end else begin
      if (start) begin
        sel           <= grant;
        m_udp_dest_ip <= peer_ip;
      end
      if (pay_hs) begin
        if (m_udp_payload_axis_tlast) begin
          word_cnt     <= '0;
          last_sel     <= sel;
          pkt_cnt[sel] <= pkt_cnt[sel] + 32'd1;
        end else begin
          word_cnt <= word_cnt + 1'b1;
        end
      end
    end
  end

endmodule
